// File: rtl/pwm_channel_scheduler.sv
// Round-robin RC-PWM pulse-width scheduler: one shared measurement counter visits
// each channel in turn and keeps a per-channel hysteresis decision and valid bit.
module pwm_channel_scheduler #(
    parameter int CHANNELS           = 8,
    parameter int MAX_COUNTER_VALUE  = 2000,
    parameter int HIGH_COUNTER_VALUE = 1800,
    parameter int LOW_COUNTER_VALUE  = 1200,
    parameter int TIMEOUT_VALUE      = 25000
) (
    input  logic                                   clock_i,
    input  logic                                   reset_i,
    input  logic                                   enable_i,
    input  logic [CHANNELS-1:0]                    pwm_i,
    output logic [CHANNELS-1:0]                    outputs_o,
    output logic [CHANNELS-1:0]                    valid_o,
    output logic [$clog2(CHANNELS)-1:0]            channel_o,
    output logic [$clog2(MAX_COUNTER_VALUE+1)-1:0] width_o,
    output logic                                   strobe_o
);

    localparam int CH_W  = $clog2(CHANNELS);
    localparam int WID_W = $clog2(MAX_COUNTER_VALUE + 1);
    localparam int TMR_W = $clog2(TIMEOUT_VALUE);

    localparam logic [WID_W-1:0] WID_MAX  = WID_W'(MAX_COUNTER_VALUE);
    localparam logic [WID_W-1:0] WID_HIGH = WID_W'(HIGH_COUNTER_VALUE);
    localparam logic [WID_W-1:0] WID_LOW  = WID_W'(LOW_COUNTER_VALUE);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_VALUE - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_LOW,
        S_WAIT_RISE,
        S_MEASURE,
        S_UPDATE
    } state_t;

    state_t             state_q, state_d;
    logic [CHANNELS-1:0] sync1_q, sync1_d;
    logic [CHANNELS-1:0] sync2_q, sync2_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [WID_W-1:0]    width_q, width_d;
    logic                ok_q, ok_d;
    logic [CHANNELS-1:0] outputs_q, outputs_d;
    logic [CHANNELS-1:0] valid_q, valid_d;
    logic [CH_W-1:0]     channel_q, channel_d;
    logic [WID_W-1:0]    width_out_q, width_out_d;
    logic                strobe_q, strobe_d;

    logic                sel;
    logic [TMR_W-1:0]    timer_inc;

    always_comb begin
        sel       = sync2_q[channel_q];
        // Saturate so a long MEASURE entered late in the wait window cannot wrap.
        timer_inc = (timer_q == TMR_LAST) ? timer_q : timer_q + TMR_W'(1);

        sync1_d     = pwm_i;
        sync2_d     = sync1_q;
        state_d     = state_q;
        timer_d     = timer_q;
        width_d     = width_q;
        ok_d        = ok_q;
        outputs_d   = outputs_q;
        valid_d     = valid_q;
        channel_d   = channel_q;
        width_out_d = width_out_q;
        strobe_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable_i) begin
                    state_d = S_WAIT_LOW;
                    timer_d = '0;
                end
            end
            S_WAIT_LOW: begin
                timer_d = timer_inc;
                if (!enable_i) begin
                    state_d = S_IDLE;
                end else if (timer_q == TMR_LAST) begin
                    state_d = S_UPDATE;
                    ok_d    = 1'b0;
                end else if (!sel) begin
                    state_d = S_WAIT_RISE;
                end
            end
            S_WAIT_RISE: begin
                timer_d = timer_inc;
                if (!enable_i) begin
                    state_d = S_IDLE;
                end else if (timer_q == TMR_LAST) begin
                    state_d = S_UPDATE;
                    ok_d    = 1'b0;
                end else if (sel) begin
                    state_d = S_MEASURE;
                    width_d = WID_W'(1);
                end
            end
            S_MEASURE: begin
                timer_d = timer_inc;
                if (!enable_i) begin
                    state_d = S_IDLE;
                end else if (sel) begin
                    if (width_q == WID_MAX) begin
                        state_d = S_UPDATE;
                        ok_d    = 1'b0;
                    end else begin
                        width_d = width_q + WID_W'(1);
                    end
                end else begin
                    state_d = S_UPDATE;
                    ok_d    = 1'b1;
                end
            end
            S_UPDATE: begin
                strobe_d = 1'b1;
                if (ok_q) begin
                    valid_d[channel_q] = 1'b1;
                    width_out_d        = width_q;
                    if (width_q >= WID_HIGH)
                        outputs_d[channel_q] = 1'b1;
                    else if (width_q <= WID_LOW)
                        outputs_d[channel_q] = 1'b0;
                end else begin
                    valid_d[channel_q]   = 1'b0;
                    outputs_d[channel_q] = 1'b0;
                end
                channel_d = (channel_q == CH_LAST) ? '0 : channel_q + CH_W'(1);
                timer_d   = '0;
                state_d   = enable_i ? S_WAIT_LOW : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            sync1_q     <= '0;
            sync2_q     <= '0;
            timer_q     <= '0;
            width_q     <= '0;
            ok_q        <= 1'b0;
            outputs_q   <= '0;
            valid_q     <= '0;
            channel_q   <= '0;
            width_out_q <= '0;
            strobe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            timer_q     <= timer_d;
            width_q     <= width_d;
            ok_q        <= ok_d;
            outputs_q   <= outputs_d;
            valid_q     <= valid_d;
            channel_q   <= channel_d;
            width_out_q <= width_out_d;
            strobe_q    <= strobe_d;
        end
    end

    assign outputs_o = outputs_q;
    assign valid_o   = valid_q;
    assign channel_o = channel_q;
    assign width_o   = width_out_q;
    assign strobe_o  = strobe_q;

endmodule
